// File: rtl/mem_bus_router.sv
// mem_bus_router
//   Registered memory-bus router. It connects one CPU-side master port to NUM_SLAVES
//   slave regions. The top SEL_BITS of the request address are decoded against a
//   per-slave tag table, and the lowest-indexed matching slave wins. A single access
//   is then run through a req/ready handshake that allows wait states. An access
//   completes with an error when the address is unmapped or the slave times out.
//
//   Ports
//     CLK, RESET        clock (rising edge), asynchronous active-high reset
//     MEM_ENABLE        master request, held high until MEM_READY
//     MEM_WRITE         1 = write, 0 = read
//     MEM_ADDR          request address
//     MEM_DATA_W        write data
//     MEM_DATA_R        read data; valid with MEM_READY and held until the next completion
//     MEM_READY         one-cycle completion pulse
//     MEM_ERROR         valid with MEM_READY: unmapped address or timeout
//     ERR_COUNT         saturating count of errored accesses
//     S_MEM_ENABLE      one-hot slave request
//     S_MEM_WRITE       one-hot write strobe, only asserted together with S_MEM_ENABLE
//     S_MEM_ADDR        latched address, shared by all slaves
//     S_MEM_DATA_W      latched write data, shared by all slaves
//     S_MEM_DATA_R      read data; slice k belongs to slave k
//     S_MEM_READY       per-slave completion; only the selected slave is looked at
module mem_bus_router #(
   parameter int                              ADDR_W     = 16,
   parameter int                              DATA_W     = 16,
   parameter int                              NUM_SLAVES = 2,
   parameter int                              SEL_BITS   = 4,
   parameter logic [NUM_SLAVES*SEL_BITS-1:0]  SLAVE_TAGS = {4'hA, 4'h0},
   parameter int                              TIMEOUT    = 15
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         MEM_ENABLE,
   input  logic                         MEM_WRITE,
   input  logic [ADDR_W-1:0]            MEM_ADDR,
   input  logic [DATA_W-1:0]            MEM_DATA_W,
   output logic [DATA_W-1:0]            MEM_DATA_R,
   output logic                         MEM_READY,
   output logic                         MEM_ERROR,
   output logic [7:0]                   ERR_COUNT,
   output logic [NUM_SLAVES-1:0]        S_MEM_ENABLE,
   output logic [NUM_SLAVES-1:0]        S_MEM_WRITE,
   output logic [ADDR_W-1:0]            S_MEM_ADDR,
   output logic [DATA_W-1:0]            S_MEM_DATA_W,
   input  logic [NUM_SLAVES*DATA_W-1:0] S_MEM_DATA_R,
   input  logic [NUM_SLAVES-1:0]        S_MEM_READY
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   // The counter only has to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit TMO_EN = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state_reg;
   logic [SEL_W-1:0]    sel_reg;
   logic [CNT_W-1:0]    wait_cnt_reg;
   logic                write_reg;

   logic [SEL_BITS-1:0]   addr_tag;
   logic [NUM_SLAVES-1:0] tag_match;
   logic                  hit;
   logic [SEL_W-1:0]      hit_idx;
   logic [NUM_SLAVES-1:0] hit_onehot;
   logic [DATA_W-1:0]     sel_rdata;
   logic                  sel_ready;
   logic                  timeout_hit;
   logic [7:0]            err_count_next;

   assign addr_tag = MEM_ADDR[ADDR_W-1 -: SEL_BITS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_tag
         assign tag_match[gi] = (addr_tag == SLAVE_TAGS[gi*SEL_BITS +: SEL_BITS]);
      end
   endgenerate

   // Scan from the highest index down so that the lowest matching index wins
   // when two slaves share a tag.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if (tag_match[k]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(k);
         end
      end
   end

   assign hit_onehot = NUM_SLAVES'(1) << hit_idx;

   // Only the slave that owns the current access is looked at.
   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel_reg == SEL_W'(k)) begin
            sel_rdata = S_MEM_DATA_R[k*DATA_W +: DATA_W];
            sel_ready = S_MEM_READY[k];
         end
      end
   end

   assign timeout_hit    = TMO_EN && (wait_cnt_reg == TMO_LAST);
   assign err_count_next = (ERR_COUNT == 8'hFF) ? 8'hFF : ERR_COUNT + 8'd1;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg    <= ST_IDLE;
         sel_reg      <= '0;
         wait_cnt_reg <= '0;
         write_reg    <= 1'b0;
         MEM_DATA_R   <= '0;
         MEM_READY    <= 1'b0;
         MEM_ERROR    <= 1'b0;
         ERR_COUNT    <= 8'h00;
         S_MEM_ENABLE <= '0;
         S_MEM_WRITE  <= '0;
         S_MEM_ADDR   <= '0;
         S_MEM_DATA_W <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               MEM_READY <= 1'b0;
               MEM_ERROR <= 1'b0;
               if (MEM_ENABLE) begin
                  S_MEM_ADDR   <= MEM_ADDR;
                  S_MEM_DATA_W <= MEM_DATA_W;
                  write_reg    <= MEM_WRITE;
                  wait_cnt_reg <= '0;
                  if (hit) begin
                     sel_reg      <= hit_idx;
                     S_MEM_ENABLE <= hit_onehot;
                     S_MEM_WRITE  <= MEM_WRITE ? hit_onehot : '0;
                     state_reg    <= ST_ACCESS;
                  end else begin
                     // An unmapped address never reaches a slave.
                     MEM_DATA_R <= '0;
                     MEM_READY  <= 1'b1;
                     MEM_ERROR  <= 1'b1;
                     ERR_COUNT  <= err_count_next;
                     state_reg  <= ST_DONE;
                  end
               end
            end

            ST_ACCESS: begin
               // Ready is tested before timeout, so a ready in the last allowed
               // cycle still counts as a good access.
               if (sel_ready) begin
                  if (!write_reg) begin
                     MEM_DATA_R <= sel_rdata;
                  end
                  S_MEM_ENABLE <= '0;
                  S_MEM_WRITE  <= '0;
                  MEM_READY    <= 1'b1;
                  MEM_ERROR    <= 1'b0;
                  state_reg    <= ST_DONE;
               end else if (timeout_hit) begin
                  S_MEM_ENABLE <= '0;
                  S_MEM_WRITE  <= '0;
                  MEM_DATA_R   <= '0;
                  MEM_READY    <= 1'b1;
                  MEM_ERROR    <= 1'b1;
                  ERR_COUNT    <= err_count_next;
                  state_reg    <= ST_DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
            end

            ST_DONE: begin
               MEM_READY <= 1'b0;
               MEM_ERROR <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
